// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised register file.
package regfile_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int DEPTH_DEF   = 16;
    localparam int AW_DEF      = $clog2(DEPTH_DEF);
    localparam int PC_IDX_DEF  = DEPTH_DEF - 1;
    localparam int PC_STEP_DEF = 4;

    typedef logic [WIDTH_DEF-1:0] word_t;
    typedef logic [AW_DEF-1:0]    addr_t;

endpackage

// File: rtl/regfile_cell.sv
// One storage word: load-enabled register with asynchronous active-low clear.
module regfile_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Word storage: cleared on reset, loaded when enabled, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {WIDTH{1'b0}};
        end else if (load_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/param_register_file.sv
// Register file: one write port, two combinational read ports with optional bypass,
// an auto-incrementing PC register and a per-register pending scoreboard.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int AW      = $clog2(DEPTH),
    parameter int PC_IDX  = DEPTH - 1,
    parameter int PC_STEP = PC_STEP_DEF,
    parameter int BYPASS  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             rd1_pend,
    output logic             rd2_pend,
    input  logic             mark_en,
    input  logic [AW-1:0]    mark_idx,
    input  logic             pc_inc,
    output logic [WIDTH-1:0] pc
);

    localparam logic [WIDTH-1:0] PC_STEP_W = WIDTH'(PC_STEP);
    localparam logic [DEPTH-1:0] ONE_HOT0  = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs_s [DEPTH];
    logic [WIDTH-1:0] cell_d_s [DEPTH];
    logic [DEPTH-1:0] cell_load_s;
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [DEPTH-1:0] clr_s;
    logic [DEPTH-1:0] set_s;
    logic             byp_en_s;

    // Forwarding is suppressed while reset holds the state cleared.
    assign byp_en_s = (BYPASS != 0) && we && reset;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            if (gi == PC_IDX) begin : g_pc
                logic wr_hit_s;
                assign wr_hit_s        = we && (wa == AW'(gi));
                assign cell_load_s[gi] = wr_hit_s || pc_inc;
                // A write to the PC takes priority over the increment.
                assign cell_d_s[gi]    = wr_hit_s ? wd : (regs_s[gi] + PC_STEP_W);
            end else begin : g_gp
                assign cell_load_s[gi] = we && (wa == AW'(gi));
                assign cell_d_s[gi]    = wd;
            end

            regfile_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk    (clk),
                .rst_n  (reset),
                .load_i (cell_load_s[gi]),
                .d_i    (cell_d_s[gi]),
                .q_o    (regs_s[gi])
            );
        end
    endgenerate

    // Pending next state: a write clears, a mark sets, and the mark wins on collision.
    always_comb begin
        clr_s  = {DEPTH{1'b0}};
        set_s  = {DEPTH{1'b0}};
        if (we) begin
            clr_s = ONE_HOT0 << wa;
        end else begin
            clr_s = {DEPTH{1'b0}};
        end
        if (mark_en) begin
            set_s = ONE_HOT0 << mark_idx;
        end else begin
            set_s = {DEPTH{1'b0}};
        end
        pend_d = (pend_q & ~clr_s) | set_s;
    end

    // Pending scoreboard storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= {DEPTH{1'b0}};
        end else begin
            pend_q <= pend_d;
        end
    end

    // Read port 1 with optional same-cycle forwarding of the write port.
    always_comb begin
        rd1      = regs_s[ra1];
        rd1_pend = pend_q[ra1];
        if (byp_en_s && (wa == ra1)) begin
            rd1      = wd;
            rd1_pend = 1'b0;
        end else begin
            rd1      = regs_s[ra1];
            rd1_pend = pend_q[ra1];
        end
    end

    // Read port 2 with optional same-cycle forwarding of the write port.
    always_comb begin
        rd2      = regs_s[ra2];
        rd2_pend = pend_q[ra2];
        if (byp_en_s && (wa == ra2)) begin
            rd2      = wd;
            rd2_pend = 1'b0;
        end else begin
            rd2      = regs_s[ra2];
            rd2_pend = pend_q[ra2];
        end
    end

    assign pc = regs_s[PC_IDX];

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench: a bypassing and a non-bypassing instance share one stimulus stream.
module tb_param_register_file;
    import regfile_pkg::*;

    logic        clk;
    logic        reset;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic        mark_en;
    logic [3:0]  mark_idx;
    logic        pc_inc;

    logic [31:0] rd1_b, rd2_b, pc_b;
    logic        p1_b, p2_b;
    logic [31:0] rd1_n, rd2_n, pc_n;
    logic        p1_n, p2_n;

    int checks;
    int errors;

    word_t       m_regs [16];
    logic [15:0] m_pend;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    param_register_file #(.BYPASS(1)) u_dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .rd1_pend(p1_b), .rd2_pend(p2_b),
        .mark_en(mark_en), .mark_idx(mark_idx), .pc_inc(pc_inc), .pc(pc_b)
    );

    param_register_file #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .rd1_pend(p1_n), .rd2_pend(p2_n),
        .mark_en(mark_en), .mark_idx(mark_idx), .pc_inc(pc_inc), .pc(pc_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] ra, input bit byp);
        if (byp && we && reset && (wa == ra)) return wd;
        return m_regs[ra];
    endfunction

    function automatic logic [31:0] exp_pend(input logic [3:0] ra, input bit byp);
        if (byp && we && reset && (wa == ra)) return 32'd0;
        return {31'd0, m_pend[ra]};
    endfunction

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // Expected outputs for the inputs currently applied, pushed in sampling order.
    task automatic push_all();
        push_exp("rd1_byp",  exp_rd(ra1, 1'b1));
        push_exp("rd2_byp",  exp_rd(ra2, 1'b1));
        push_exp("pend1_byp", exp_pend(ra1, 1'b1));
        push_exp("pend2_byp", exp_pend(ra2, 1'b1));
        push_exp("pc_byp",   m_regs[15]);
        push_exp("rd1_nb",   exp_rd(ra1, 1'b0));
        push_exp("rd2_nb",   exp_rd(ra2, 1'b0));
        push_exp("pend1_nb", exp_pend(ra1, 1'b0));
        push_exp("pend2_nb", exp_pend(ra2, 1'b0));
        push_exp("pc_nb",    m_regs[15]);
    endtask

    task automatic pop_one(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: got empty queue expected entry");
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_val(t, obs, e);
        end
    endtask

    task automatic pop_all();
        pop_one(rd1_b);
        pop_one(rd2_b);
        pop_one({31'd0, p1_b});
        pop_one({31'd0, p2_b});
        pop_one(pc_b);
        pop_one(rd1_n);
        pop_one(rd2_n);
        pop_one({31'd0, p1_n});
        pop_one({31'd0, p2_n});
        pop_one(pc_n);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_pend = 16'd0;
    endtask

    task automatic model_edge();
        logic [31:0] old_pc;
        if (reset) begin
            old_pc = m_regs[15];
            if (we) begin
                m_regs[wa] = wd;
                m_pend[wa] = 1'b0;
            end
            if (pc_inc && !(we && wa == 4'd15)) m_regs[15] = old_pc + 32'd4;
            if (mark_en) m_pend[mark_idx] = 1'b1;
        end
    endtask

    // One cycle: drive after posedge, compare on negedge, advance model on posedge.
    task automatic cyc(input logic we_v, input logic [3:0] wa_v, input logic [31:0] wd_v,
                       input logic [3:0] r1, input logic [3:0] r2,
                       input logic me, input logic [3:0] mi, input logic pi);
        we = we_v; wa = wa_v; wd = wd_v; ra1 = r1; ra2 = r2;
        mark_en = me; mark_idx = mi; pc_inc = pi;
        push_all();
        @(negedge clk);
        pop_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        we = 1'b0; wa = 4'd0; wd = 32'd0; ra1 = 4'd0; ra2 = 4'd15;
        mark_en = 1'b0; mark_idx = 4'd0; pc_inc = 1'b0;
        model_clear();

        // Reset state, including an edge with activity while held.
        cyc(1'b0, 4'd0, 32'd0, 4'd0, 4'd15, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd4, 32'h1234, 4'd3, 4'd15, 1'b1, 4'd4, 1'b1);
        reset = 1'b1;

        // Write r3 with same-cycle and next-cycle reads.
        cyc(1'b1, 4'd3, 32'hDEADBEEF, 4'd3, 4'd4, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0,        4'd3, 4'd3, 1'b0, 4'd0, 1'b0);

        // Two writes then dual-port and shared-address reads.
        cyc(1'b1, 4'd5, 32'h11, 4'd0, 4'd1, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd6, 32'h22, 4'd5, 4'd1, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0,  4'd5, 4'd6, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0,  4'd5, 4'd5, 1'b0, 4'd0, 1'b0);

        // PC increments, wrap, and write-over-increment priority.
        cyc(1'b0, 4'd0,  32'd0,        4'd15, 4'd0, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0,  32'd0,        4'd15, 4'd0, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0,  32'd0,        4'd15, 4'd0, 1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd15, 32'hFFFFFFFC, 4'd15, 4'd0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0,  32'd0,        4'd15, 4'd0, 1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd15, 32'h100,      4'd0,  4'd1, 1'b0, 4'd0, 1'b1);
        cyc(1'b1, 4'd8,  32'h88,       4'd15, 4'd0, 1'b0, 4'd0, 1'b1);

        // Pending: mark, clear by write, mark-and-write collision.
        cyc(1'b0, 4'd0, 32'd0,  4'd7, 4'd7, 1'b1, 4'd7, 1'b0);
        cyc(1'b0, 4'd0, 32'd0,  4'd7, 4'd6, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd7, 32'h77, 4'd7, 4'd6, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd7, 32'h78, 4'd7, 4'd0, 1'b1, 4'd7, 1'b0);
        cyc(1'b0, 4'd0, 32'd0,  4'd7, 4'd7, 1'b0, 4'd0, 1'b0);

        // Same-cycle read of a write: old value without forwarding.
        cyc(1'b1, 4'd2, 32'hA5, 4'd2, 4'd2, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0,  4'd2, 4'd2, 1'b0, 4'd0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
        end

        // Fill every register with nonzero data and mark every other one.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 4'(i), 32'h1000 + 32'(i) * 32'h11, 4'(i), 4'(15 - i),
                1'b0, 4'd0, 1'b0);
        end
        for (int i = 0; i < 16; i += 2) begin
            cyc(1'b0, 4'd0, 32'd0, 4'(i), 4'(i + 1), 1'b1, 4'(i), 1'b0);
        end

        // Asynchronous reset between edges: outputs clear immediately.
        we = 1'b0; mark_en = 1'b0; pc_inc = 1'b0; ra1 = 4'd2; ra2 = 4'd15;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        push_all();
        pop_all();

        // Held reset: edges with write/mark/inc leave everything at zero.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 4'(i + 8), 32'hFFFF0000 | 32'(i), 4'(i), 4'(15 - i),
                1'b1, 4'(i), 1'b1);
        end
        reset = 1'b1;
        cyc(1'b0, 4'd0, 32'd0, 4'd9, 4'd15, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 4'd8, 4'd0,  1'b0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 32'd0, 4'd15, 4'd8, 1'b0, 4'd0, 1'b0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
